// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register word offsets
// (adr[4:2]) and the VECTOR layout, plus the lowest-index priority helper.
package wb_irq_ctrl_pkg;

   localparam logic [2:0] IRQ_STATUS  = 3'd0;
   localparam logic [2:0] IRQ_ENABLE  = 3'd1;
   localparam logic [2:0] IRQ_PENDING = 3'd2;
   localparam logic [2:0] IRQ_EDGE    = 3'd3;
   localparam logic [2:0] IRQ_POL     = 3'd4;
   localparam logic [2:0] IRQ_SWSET   = 3'd5;
   localparam logic [2:0] IRQ_VECTOR  = 3'd6;
   localparam logic [2:0] IRQ_RSVD    = 3'd7;

   localparam int unsigned VECTOR_VALID_BIT = 31;

   // Scans from the top down so the last hit, the lowest set index, wins.
   function automatic logic [4:0] lowest_set(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int unsigned i = 32; i > 0; i--) begin
         if (v[i-1]) idx = 5'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone signal bundle with master and slave views.
interface wb_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   dat_w;
   logic [DATA_WIDTH-1:0]   dat_r;
   logic [DATA_WIDTH/8-1:0] sel;
   logic                    we;
   logic                    cyc;
   logic                    stb;
   logic                    ack;
   logic                    err;

   modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
   modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/irq_src_cond.sv
// One interrupt source: 2-flop synchroniser with polarity, edge/level event
// detection and its STATUS bit (set beats W1C).
module irq_src_cond
   import wb_irq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic irq_raw,
   input  logic pol,
   input  logic edge_mode,
   input  logic w1c,
   input  logic sw_set,
   output logic status
);

   logic s0;
   logic s1;
   logic s1_d;
   logic src_evt;

   assign src_evt = edge_mode ? (s1 & ~s1_d) : s1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s0     <= 1'b0;
         s1     <= 1'b0;
         s1_d   <= 1'b0;
         status <= 1'b0;
      end else begin
         s0     <= irq_raw ^ pol;
         s1     <= s0;
         s1_d   <= s1;
         status <= src_evt | sw_set | (status & ~w1c);
      end
   end

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone-slave interrupt controller: register decode, per-source config,
// priority vector and the registered irq output.
module wb_irq_ctrl
   import wb_irq_ctrl_pkg::*;
#(
   parameter int unsigned WB_ADDR_WIDTH = 32,
   parameter int unsigned WB_DATA_WIDTH = 32,
   parameter int unsigned N_IRQ         = 8
) (
   input  logic             clk,
   input  logic             rstn,
   wb_if.slave              s,
   input  logic [N_IRQ-1:0] irq_i,
   output logic             irq
);

   if (WB_DATA_WIDTH != 32 || WB_ADDR_WIDTH < 5 || N_IRQ < 1 || N_IRQ > 31) begin : g_param_check
      $error("wb_irq_ctrl: unsupported parameter combination");
   end

   logic                     ack_r;
   logic                     req;
   logic                     wr;
   logic [2:0]               off;
   logic [WB_DATA_WIDTH-1:0] dat_r_q;
   logic [WB_DATA_WIDTH-1:0] rd_data;
   logic [WB_DATA_WIDTH-1:0] vector;
   logic [N_IRQ-1:0]         status_bits;
   logic [N_IRQ-1:0]         enable_r;
   logic [N_IRQ-1:0]         edge_r;
   logic [N_IRQ-1:0]         pol_r;
   logic [N_IRQ-1:0]         pending;
   logic [N_IRQ-1:0]         wmask;
   logic [N_IRQ-1:0]         wdat;
   logic [N_IRQ-1:0]         w1c;
   logic [N_IRQ-1:0]         swset;

   // The access is captured on the edge that raises ack, so a master dropping
   // cyc/stb afterwards cannot cancel it.
   assign req = s.cyc & s.stb & ~ack_r;
   assign wr  = req & s.we;
   assign off = s.adr[4:2];

   always_comb begin
      wmask = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         wmask[i] = s.sel[i/8];
      end
   end

   assign wdat    = s.dat_w[N_IRQ-1:0] & wmask;
   assign w1c     = (wr && off == IRQ_STATUS) ? wdat : '0;
   assign swset   = (wr && off == IRQ_SWSET)  ? wdat : '0;
   assign pending = status_bits & enable_r;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_src
      irq_src_cond u_src (
         .clk       (clk),
         .rstn      (rstn),
         .irq_raw   (irq_i[i]),
         .pol       (pol_r[i]),
         .edge_mode (edge_r[i]),
         .w1c       (w1c[i]),
         .sw_set    (swset[i]),
         .status    (status_bits[i])
      );
   end

   always_comb begin
      vector                   = '0;
      vector[VECTOR_VALID_BIT] = |pending;
      vector[4:0]              = lowest_set(32'(pending));
   end

   always_comb begin
      rd_data = '0;
      case (off)
         IRQ_STATUS:  rd_data[N_IRQ-1:0] = status_bits;
         IRQ_ENABLE:  rd_data[N_IRQ-1:0] = enable_r;
         IRQ_PENDING: rd_data[N_IRQ-1:0] = pending;
         IRQ_EDGE:    rd_data[N_IRQ-1:0] = edge_r;
         IRQ_POL:     rd_data[N_IRQ-1:0] = pol_r;
         IRQ_VECTOR:  rd_data            = vector;
         default:     rd_data            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ack_r    <= 1'b0;
         dat_r_q  <= '0;
         enable_r <= '0;
         edge_r   <= '0;
         pol_r    <= '0;
         irq      <= 1'b0;
      end else begin
         ack_r <= req;
         irq   <= |pending;
         if (req && !s.we) dat_r_q <= rd_data;
         if (wr) begin
            case (off)
               IRQ_ENABLE: enable_r <= (enable_r & ~wmask) | wdat;
               IRQ_EDGE:   edge_r   <= (edge_r   & ~wmask) | wdat;
               IRQ_POL:    pol_r    <= (pol_r    & ~wmask) | wdat;
               default:    ;
            endcase
         end
      end
   end

   assign s.ack   = ack_r;
   assign s.dat_r = dat_r_q;
   assign s.err   = 1'b0;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Scoreboard bench for wb_irq_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the register/interrupt rules.
module tb_wb_irq_ctrl;

   localparam int unsigned N = 8;

   logic         clk   = 1'b0;
   logic         rstn  = 1'b0;
   logic [N-1:0] irq_i = '0;
   logic         irq;

   wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   wb_irq_ctrl #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_IRQ(N)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .s     (bus),
      .irq_i (irq_i),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   bit          mon_en      = 1'b0;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      logic [2:0]  off;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state: registers plus a history of polarity-adjusted samples.
   bit [N-1:0] st, en, ed, po;
   bit         ack_m, irq_m;
   bit [N-1:0] smp[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] off);
      logic [31:0] v;
      bit [N-1:0]  pend;
      v    = '0;
      pend = st & en;
      case (off)
         3'd0: v = 32'(st);
         3'd1: v = 32'(en);
         3'd2: v = 32'(pend);
         3'd3: v = 32'(ed);
         3'd4: v = 32'(po);
         3'd6: for (int i = N - 1; i >= 0; i--) if (pend[i]) v = 32'h8000_0000 | 32'(i);
         default: v = '0;
      endcase
      return v;
   endfunction

   always @(posedge clk or negedge rstn) begin
      bit [N-1:0] lvl, prv, bm, wd, clr, sw, nst;
      bit         acc, ev;
      logic [2:0] off;
      if (!rstn) begin
         st = '0; en = '0; ed = '0; po = '0;
         ack_m = 1'b0; irq_m = 1'b0;
         exp_q.delete();
         smp.delete();
         repeat (3) smp.push_back('0);
      end else begin
         acc = bus.cyc && bus.stb && !ack_m;
         off = bus.adr[4:2];
         for (int i = 0; i < N; i++) bm[i] = bus.sel[i/8];
         wd  = bus.dat_w[N-1:0] & bm;
         clr = (acc && bus.we && off == 3'd0) ? wd : '0;
         sw  = (acc && bus.we && off == 3'd5) ? wd : '0;
         if (acc) exp_q.push_back('{!bus.we, model_read(off), off});
         // smp[1] is the synchronised level seen now, smp[2] the one before it.
         lvl = smp[1];
         prv = smp[2];
         smp.push_front(irq_i ^ po);
         void'(smp.pop_back());
         irq_m = |(st & en);
         for (int i = 0; i < N; i++) begin
            ev = ed[i] ? (lvl[i] && !prv[i]) : lvl[i];
            if (ev || sw[i])  nst[i] = 1'b1;
            else if (clr[i])  nst[i] = 1'b0;
            else              nst[i] = st[i];
         end
         st = nst;
         if (acc && bus.we) begin
            case (off)
               3'd1: en = (en & ~bm) | wd;
               3'd3: ed = (ed & ~bm) | wd;
               3'd4: po = (po & ~bm) | wd;
               default: ;
            endcase
         end
         ack_m = acc;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("irq", 32'(irq), 32'(irq_m));
         chk("ack", 32'(bus.ack), 32'(ack_m));
         chk("err", 32'(bus.err), 32'd0);
         if (bus.ack) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ack: got ack=1 expected no outstanding access at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               if (e.is_read) chk($sformatf("rd_off%0d", e.off), bus.dat_r, e.data);
            end
         end
      end
   end

   task automatic bus_xfer(input bit we, input logic [2:0] off, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
      int unsigned n;
      @(negedge clk);
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = we;
      bus.adr   = {27'($urandom), off, 2'b00};
      bus.dat_w = d;
      bus.sel   = sel;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ack && n < 8);
      if (!bus.ack) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout: got no ack after %0d cycles expected ack after 1", n);
      end
      rd      = bus.dat_r;
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel = 4'hF);
      logic [31:0] unused;
      bus_xfer(1'b1, off, d, sel, unused);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] r;
      bus_xfer(1'b0, off, '0, 4'hF, r);
      chk(name, r, exp);
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0]  pat;
      int unsigned k;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rstn = 1'b1;
      mon_en = 1'b1;

      // Reset values
      for (int o = 0; o < 8; o++) rd_chk($sformatf("reset_off%0d", o), 3'(o), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);

      // Level source: 4-cycle latency, W1C while held does not stick
      wr(3'd4, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd1, 32'h01);
      step(1);
      irq_i[0] = 1'b1;
      step(3);
      chk("lvl_irq_cyc3", 32'(irq), 32'd0);
      step(1);
      chk("lvl_irq_cyc4", 32'(irq), 32'd1);
      wr(3'd0, 32'h01);
      rd_chk("lvl_w1c_held", 3'd0, 32'h01);
      irq_i[0] = 1'b0;
      step(4);
      wr(3'd0, 32'h01);
      step(2);
      chk("lvl_irq_clear", 32'(irq), 32'd0);
      rd_chk("lvl_status_clear", 3'd0, 32'h00);

      // Edge source
      wr(3'd3, 32'h04);
      wr(3'd1, 32'h04);
      step(1);
      irq_i[2] = 1'b1;
      step(3);
      irq_i[2] = 1'b0;
      step(4);
      rd_chk("edge_status", 3'd0, 32'h04);
      rd_chk("edge_vector", 3'd6, 32'h8000_0002);
      irq_i[2] = 1'b1;
      step(5);
      wr(3'd0, 32'h04);
      step(4);
      rd_chk("edge_held_no_reset", 3'd0, 32'h00);

      // W1C on the same edge a new event is latched: set wins
      irq_i[2] = 1'b0;
      step(4);
      irq_i[2] = 1'b1;
      step(1);
      wr(3'd0, 32'h04);
      rd_chk("set_beats_w1c", 3'd0, 32'h04);

      irq_i = '0;
      step(4);
      wr(3'd0, 32'hFF);
      wr(3'd1, 32'h80);
      wr(3'd5, 32'h81);
      rd_chk("swset_status", 3'd0, 32'h81);
      rd_chk("swset_pending", 3'd2, 32'h80);
      rd_chk("swset_vector", 3'd6, 32'h8000_0007);
      rd_chk("swset_reads0", 3'd5, 32'h0);

      // Byte lanes and unmapped offset
      wr(3'd1, 32'hFFFF_FFFF, 4'b0001);
      rd_chk("sel_lane0", 3'd1, 32'hFF);
      wr(3'd1, 32'h0000_0000, 4'b0010);
      rd_chk("sel_lane1_nochange", 3'd1, 32'hFF);
      wr(3'd7, 32'hFFFF_FFFF);
      rd_chk("rsvd_reads0", 3'd7, 32'h0);
      wr(3'd1, 32'h80);

      // Continuous stb over four reads
      @(negedge clk);
      pat[0]  = bus.ack;
      k       = 0;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
      bus.adr = 32'h0;
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         pat[c] = bus.ack;
         if (bus.ack) begin
            k++;
            bus.adr = {27'd0, 3'(k), 2'b00};
         end
      end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      chk("ack_pattern", 32'(pat), 32'h0000_00AA);

      // Reset while an access is pending
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0;
      #2 rstn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("ack_in_reset", 32'(bus.ack), 32'd0);
      end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      @(negedge clk);
      #1 rstn = 1'b1;
      for (int o = 0; o < 8; o++) rd_chk($sformatf("rst2_off%0d", o), 3'(o), 32'd0);
      chk("rst2_irq", 32'(irq), 32'd0);

      // Random traffic, checked through the scoreboard
      for (int t = 0; t < 300; t++) begin
         logic [31:0] r;
         if ($urandom_range(0, 3) == 0) irq_i = irq_i ^ N'($urandom);
         bus_xfer(1'(($urandom_range(0, 2) != 0) ? 0 : 1), 3'($urandom), $urandom,
                  4'($urandom), r);
         step($urandom_range(0, 3));
      end

      step(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
